// File: rtl/four_bit_comparator.sv
// Registered magnitude comparator. A and B are captured on in_valid and the
// one-hot eq/gt/lt result is presented one clock later with out_valid.
// SIGNED selects unsigned magnitude or two's-complement ordering.
module four_bit_comparator #(
  parameter int WIDTH  = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  logic w_eq;
  logic w_gt;
  logic w_lt;

  logic r_valid;
  logic r_eq;
  logic r_gt;
  logic r_lt;

  assign w_eq = (A == B);

  // Ordering depends on how the MSB is interpreted; pick it at elaboration.
  generate
    if (SIGNED) begin : g_signed
      assign w_gt = ($signed(A) > $signed(B));
    end else begin : g_unsigned
      assign w_gt = (A > B);
    end
  endgenerate

  // Exactly one flag is set: lt is whatever is neither equal nor greater.
  assign w_lt = ~w_eq & ~w_gt;

  // Capture the result on in_valid; otherwise keep flags and drop out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_eq    <= 1'b0;
      r_gt    <= 1'b0;
      r_lt    <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_eq <= w_eq;
        r_gt <= w_gt;
        r_lt <= w_lt;
      end
    end
  end

  assign out_valid = r_valid;
  assign eq        = r_eq;
  assign gt        = r_gt;
  assign lt        = r_lt;

endmodule

// File: tb/tb_four_bit_comparator.sv
// Bench for four_bit_comparator: directed cases, exhaustive sweep at full
// rate, reset behaviour and random traffic with in_valid gaps, all checked
// against an integer reference model for both unsigned and signed builds.
module tb_four_bit_comparator;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] A;
  logic [3:0] B;

  logic u_valid, u_eq, u_gt, u_lt;
  logic s_valid, s_eq, s_gt, s_lt;

  int total_cnt;
  int bad_cnt;

  // expected {out_valid, eq, gt, lt}
  logic [3:0] exp_u;
  logic [3:0] exp_s;

  four_bit_comparator #(.WIDTH(4), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A), .B(B),
    .out_valid(u_valid), .eq(u_eq), .gt(u_gt), .lt(u_lt)
  );

  four_bit_comparator #(.WIDTH(4), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A), .B(B),
    .out_valid(s_valid), .eq(s_eq), .gt(s_gt), .lt(s_lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] want);
    total_cnt++;
    if (got !== want) begin
      bad_cnt++;
      $display("FAIL %s got=%b want=%b (valid,eq,gt,lt) A=%0d B=%0d", tag, got, want, A, B);
    end
  endtask

  // Reference ordering from plain integer values: returns {eq, gt, lt}.
  function automatic logic [2:0] ref_cmp(input int a, input int b);
    if (a == b) return 3'b100;
    if (a > b)  return 3'b010;
    return 3'b001;
  endfunction

  function automatic int as_signed4(input int v);
    return (v >= 8) ? v - 16 : v;
  endfunction

  task automatic check_both(input string tag);
    check_val({tag, "_u"}, {u_valid, u_eq, u_gt, u_lt}, exp_u);
    check_val({tag, "_s"}, {s_valid, s_eq, s_gt, s_lt}, exp_s);
  endtask

  // One clock: drive at negedge, update model, sample just after posedge.
  task automatic step(input string tag, input int a, input int b, input logic v);
    @(negedge clk);
    A        = 4'(a);
    B        = 4'(b);
    in_valid = v;
    @(posedge clk);
    #1;
    if (v) begin
      exp_u = {1'b1, ref_cmp(a, b)};
      exp_s = {1'b1, ref_cmp(as_signed4(a), as_signed4(b))};
    end else begin
      exp_u = {1'b0, exp_u[2:0]};
      exp_s = {1'b0, exp_s[2:0]};
    end
    check_both(tag);
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    A         = '0;
    B         = '0;
    exp_u     = 4'b0000;
    exp_s     = 4'b0000;

    // reset state, held across edges even with in_valid high
    #2;
    check_both("reset");
    in_valid = 1'b1;
    A = 4'd3;
    B = 4'd1;
    @(posedge clk);
    #1;
    check_both("reset_hold");
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    // directed cases
    step("eq_zero", 0, 0, 1'b1);
    $display("eq_zero A=0 B=0 u=%b%b%b%b", u_valid, u_eq, u_gt, u_lt);
    step("eq_five", 5, 5, 1'b1);
    step("gt_8_2",  8, 2, 1'b1);
    $display("gt_8_2 u_gt=%b s_lt=%b", u_gt, s_lt);
    step("lt_4_5",  4, 5, 1'b1);
    step("lt_1_4",  1, 4, 1'b1);
    step("gt_9_3",  9, 3, 1'b1);
    step("hold",    0, 15, 1'b0);
    $display("hold out_valid=%b gt=%b", u_valid, u_gt);
    step("hold2",   15, 0, 1'b0);

    // exhaustive sweep, back-to-back
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        step("sweep", a, b, 1'b1);
      end
    end
    $display("sweep done total=%0d bad=%0d", total_cnt, bad_cnt);

    // asynchronous reset mid-stream, between clock edges
    @(negedge clk);
    A        = 4'd7;
    B        = 4'd2;
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    exp_u = 4'b0000;
    exp_s = 4'b0000;
    check_both("async_rst");
    @(posedge clk);
    #1;
    check_both("rst_hold");
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    step("post_rst_idle", 3, 3, 1'b0);
    step("post_rst_first", 2, 11, 1'b1);

    // random traffic with gaps
    for (int i = 0; i < 300; i++) begin
      step("rand", int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           logic'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
